sum_feeder: RTL and testbench
=============================

// Module: sum_feeder
// PURPOSE
//  Upstream stage for the zero-terminated accumulator thread. Buffers nonzero 16-bit
//  words from a producer and, on a start request, streams them into the accumulator:
//  go_l pulse with the first word, remaining words one per cycle, then a 0 terminator.
//  Captures the accumulator's total on its done pulse and presents it as result.
// PARAMETERS
//  DEPTH  8   buffer capacity in words; power of 2, >= 2
//  W      16  data width; must match the accumulator input/sum width
// PORTS
//  clk           in   1       single clock, rising edge
//  reset_l       in   1       asynchronous, active-low reset
//  wr_en         in   1       producer write strobe, active high
//  wr_data       in   W       word to buffer
//  wr_rej        out  1       1-cycle pulse: write rejected (zero word, full, or busy)
//  full          out  1       buffer holds DEPTH words
//  start_l       in   1       active-low launch request, sampled on each rising edge
//  start_rej     out  1       1-cycle pulse: start ignored (buffer empty or busy)
//  busy          out  1       high from accepted start until result capture
//  feed_go_l     out  1       to accumulator go_l
//  feed_inA      out  W       to accumulator inA
//  sum_done      in   1       from accumulator done
//  sum_in        in   W       from accumulator sum
//  result        out  W       last captured total; holds until next capture
//  result_valid  out  1       1-cycle pulse when result updates
// BEHAVIOUR
//  Reset: state IDLE, buffer empty, feed_go_l=1, feed_inA=0, busy=0, wr_rej=0,
//   start_rej=0, result=0, result_valid=0. Reset mid-stream aborts; buffer contents lost.
//  Write: accepted only when wr_en & wr_data!=0 & ~full & state==IDLE; else wr_rej next cycle.
//   Zero words are never stored (0 is the terminator).
//  FSM, all outputs registered:
//   IDLE   feed_go_l=1, feed_inA=0. start_l=0 & count>0 -> GO (first word popped); start_l=0 &
//          count==0 -> stay, start_rej pulse. Simultaneous wr_en+start: write wins, start
//          sees pre-write count.
//   GO     feed_go_l=0, feed_inA=first word. Next: STREAM if words remain, else TERM.
//   STREAM feed_go_l=1, feed_inA=next word each cycle; TERM after the last word.
//   TERM   feed_go_l=1, feed_inA=0. sum_done=1 -> capture sum_in into result,
//          result_valid pulse, -> IDLE. Stays in TERM driving 0 until sum_done.
//  start_l while busy: ignored, start_rej pulse.
//  Latency for N words, start sampled at edge 0: GO in cycle 1, words in cycles 1..N,
//   TERM cycle N+1 (sum_done expected same cycle), result_valid in cycle N+2, busy low in N+2.
//  Arithmetic: total is the accumulator's modulo-2^W sum; no overflow flag.
//  Buffer: circular, rd/wr pointers wrap at DEPTH; count width $clog2(DEPTH)+1.
// STRUCTURE
//  Package sum_pkg: enum logic [1:0] {IDLE, GO, STREAM, TERM} feed_state_t; WORD_W=16.
//  Sub-module sum_fifo (DEPTH, W): sync FIFO, push/pop/full/empty/count; no bypass.
//  sum_feeder = sum_fifo + FSM + result register.
// TESTING (bench instantiates sum_feeder driving sumItUp_Thread)
//  1 write 3,5,7; start -> inA 3(go_l=0),5,7,0; result=15, result_valid in cycle 5.
//  2 write 42 only; start -> GO then TERM; result=42; busy high 2 cycles, low in cycle 3.
//  3 write 0x8000,0x8001 -> result=0x0001 (wrap); write 0 -> wr_rej, count unchanged.
//  4 fill 8 words 1..8; 9th write -> wr_rej; start -> result=36; buffer empty after.
//  5 start on empty -> start_rej, feed_go_l stays 1; start mid-stream -> start_rej, no effect.
//  6 reset_l low during STREAM -> outputs to reset values immediately; next run of 2,2 -> 4.

Source files
------------

// File: rtl/sum_pkg.sv
// sum_pkg: shared types and constants for the sum_feeder slice.
//   WORD_W       data width shared with the accumulator
//   DEPTH_DEF    default buffer capacity in words
//   feed_state_t feeder FSM states
package sum_pkg;
  localparam int WORD_W    = 16;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GO     = 2'd1,
    STREAM = 2'd2,
    TERM   = 2'd3
  } feed_state_t;
endpackage

// File: rtl/sum_fifo.sv
// sum_fifo: synchronous circular FIFO, show-ahead read (pop_data is the head word).
// Ports:
//   clk, reset_l          clock, async active-low reset (pointers/count only)
//   push, push_data       write strobe and word; ignored when full
//   pop                   consume head word; ignored when empty
//   pop_data              current head word
//   full, empty, count    occupancy status
module sum_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 16
) (
  input  logic                       clk,
  input  logic                       reset_l,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  // Storage needs no reset: contents behind the pointers are never read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of 2, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sum_feeder.sv
// sum_feeder: buffers nonzero words and streams them into the zero-terminated
// accumulator (go_l with the first word, one word per cycle, then 0), then
// captures the accumulator's total on its done pulse.
// Ports:
//   clk, reset_l                 clock, async active-low reset
//   wr_en, wr_data, wr_rej       producer write; wr_rej pulses on a rejected write
//   full                         buffer holds DEPTH words
//   start_l, start_rej           launch request (active low); reject pulse
//   busy                         run in progress (accepted start .. capture)
//   feed_go_l, feed_inA          to accumulator go_l / inA
//   sum_done, sum_in             from accumulator done / sum
//   result, result_valid         captured total and its update pulse
module sum_feeder import sum_pkg::*; #(
  parameter int DEPTH = DEPTH_DEF,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         wr_rej,
  output logic         full,
  input  logic         start_l,
  output logic         start_rej,
  output logic         busy,
  output logic         feed_go_l,
  output logic [W-1:0] feed_inA,
  input  logic         sum_done,
  input  logic [W-1:0] sum_in,
  output logic [W-1:0] result,
  output logic         result_valid
);
  feed_state_t state, state_n;

  logic                  empty, pop, push, start_rej_n, capture;
  logic [W-1:0]          head;
  logic [$clog2(DEPTH):0] count;

  // A write in the same cycle as a start is still accepted; the start decision
  // uses the registered (pre-write) occupancy via empty.
  assign push    = wr_en && (wr_data != '0) && !full && (state == IDLE);
  assign capture = (state == TERM) && sum_done;

  sum_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk       (clk),
    .reset_l   (reset_l),
    .push      (push),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // State register
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) state <= IDLE;
    else          state <= state_n;
  end

  // Next state; pop advances the head into feed_inA for the next cycle.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    start_rej_n = !start_l && ((state != IDLE) || empty);
    case (state)
      IDLE:   if (!start_l && !empty) begin state_n = GO; pop = 1'b1; end
      GO,
      STREAM: if (!empty) begin state_n = STREAM; pop = 1'b1; end
              else state_n = TERM;
      TERM:   if (sum_done) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs, registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      feed_go_l    <= 1'b1;
      feed_inA     <= '0;
      busy         <= 1'b0;
      wr_rej       <= 1'b0;
      start_rej    <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      feed_go_l    <= (state_n != GO);
      feed_inA     <= pop ? head : '0;
      busy         <= (state_n != IDLE);
      wr_rej       <= wr_en && !push;
      start_rej    <= start_rej_n;
      result_valid <= capture;
      if (capture) result <= sum_in;
    end
  end

  logic unused_count;
  assign unused_count = ^count;
endmodule

// File: tb/tb_sum_feeder.sv
// Bench for sum_feeder with a behavioural zero-terminated accumulator and a
// queue-based reference model of the buffer/run behaviour.
module tb_sum_feeder;
  localparam int DEPTH = 8;
  localparam int W     = 16;

  logic         clk = 1'b0;
  logic         reset_l = 1'b1;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         start_l = 1'b1;
  logic         wr_rej, full, start_rej, busy, feed_go_l, result_valid;
  logic [W-1:0] feed_inA, result, sum_in;
  logic         sum_done;

  int n_chk = 0;
  int n_fail = 0;
  int dly = 0;

  always #5 clk = ~clk;

  sum_feeder #(.DEPTH(DEPTH), .W(W)) dut (
    .clk          (clk),
    .reset_l      (reset_l),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_rej       (wr_rej),
    .full         (full),
    .start_l      (start_l),
    .start_rej    (start_rej),
    .busy         (busy),
    .feed_go_l    (feed_go_l),
    .feed_inA     (feed_inA),
    .sum_done     (sum_done),
    .sum_in       (sum_in),
    .result       (result),
    .result_valid (result_valid)
  );

  // Accumulator stand-in: go_l loads, nonzero words add, a 0 ends the run.
  // done is raised while the 0 is presented, optionally after dly extra cycles.
  logic         acc_act;
  logic [W-1:0] acc;
  int           tcnt;
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      acc_act <= 1'b0; acc <= '0; tcnt <= 0;
    end else if (!feed_go_l) begin
      acc <= feed_inA; acc_act <= 1'b1; tcnt <= 0;
    end else if (sum_done) begin
      acc_act <= 1'b0;
    end else if (acc_act) begin
      if (feed_inA != '0) acc <= acc + feed_inA;
      else tcnt <= tcnt + 1;
    end
  end
  assign sum_done = acc_act && feed_go_l && (feed_inA == '0) && (tcnt >= dly);
  assign sum_in   = acc;

  // Reference model state
  logic [W-1:0] q[$];
  logic         f_go[$];
  logic [W-1:0] f_dat[$];
  logic         m_busy, e_wr_rej, e_start_rej, e_rv;
  logic [W-1:0] m_result, m_run_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); f_go.delete(); f_dat.delete();
    m_busy = 0; e_wr_rej = 0; e_start_rej = 0; e_rv = 0;
    m_result = '0; m_run_sum = '0;
  endtask

  // Advance the model across one edge using the inputs held before it.
  task automatic model_edge(input logic done_pre);
    int  pre_cnt;
    bit  was_busy, ok;
    int  s;
    was_busy = m_busy;
    e_wr_rej = 0; e_start_rej = 0; e_rv = 0;
    if (f_go.size() > 0) begin void'(f_go.pop_front()); void'(f_dat.pop_front()); end
    pre_cnt = q.size();
    ok = wr_en && (wr_data != 0) && (q.size() < DEPTH) && !was_busy;
    e_wr_rej = wr_en && !ok;
    if (ok) q.push_back(wr_data);
    if (!start_l) begin
      if (was_busy || pre_cnt == 0) e_start_rej = 1;
      else begin
        m_busy = 1; s = 0;
        for (int i = 0; q.size() > 0; i++) begin
          logic [W-1:0] w;
          w = q.pop_front();
          s += w;
          f_go.push_back(i != 0);
          f_dat.push_back(w);
        end
        m_run_sum = s % 65536;
      end
    end
    if (was_busy && done_pre) begin
      m_busy = 0; e_rv = 1; m_result = m_run_sum;
    end
  endtask

  task automatic compare();
    check("wr_rej", wr_rej, e_wr_rej);
    check("start_rej", start_rej, e_start_rej);
    check("busy", busy, m_busy);
    check("full", full, q.size() == DEPTH);
    check("result_valid", result_valid, e_rv);
    check("result", result, m_result);
    check("feed_go_l", feed_go_l, f_go.size() > 0 ? f_go[0] : 1'b1);
    check("feed_inA", feed_inA, f_dat.size() > 0 ? f_dat[0] : 16'h0);
  endtask

  task automatic step();
    logic dp;
    dp = sum_done;
    @(posedge clk); #1;
    model_edge(dp);
    compare();
  endtask

  task automatic do_reset();
    wr_en = 0; start_l = 1;
    reset_l = 0; #1;
    model_reset();
    compare();
    @(posedge clk); #1;
    compare();
    reset_l = 1;
  endtask

  task automatic wr(input logic [W-1:0] w);
    wr_en = 1; wr_data = w; step(); wr_en = 0;
  endtask

  // Launch and wait for result_valid; cyc is the cycle it appeared in (start edge = 0).
  task automatic launch(output int cyc);
    start_l = 0; step(); start_l = 1;
    cyc = 1;
    while (!result_valid && cyc < 40) begin step(); cyc++; end
    check("rv_seen", result_valid, 1);
  endtask

  initial begin
    int c, nb;
    #3;
    do_reset();

    // 1: three words
    wr(3); wr(5); wr(7);
    launch(c);
    check("t1_rv_cycle", c, 5);
    check("t1_result", result, 15);

    // 2: single word, busy for cycles 1..2
    wr(42);
    start_l = 0; step(); start_l = 1;
    nb = busy ? 1 : 0;
    c = 1;
    while (!result_valid && c < 40) begin step(); c++; if (busy) nb++; end
    check("t2_rv_cycle", c, 3);
    check("t2_busy_cycles", nb, 2);
    check("t2_result", result, 42);

    // 3: wrap, then a zero word is rejected and not stored
    wr(16'h8000); wr(16'h8001);
    launch(c);
    check("t3_wrap", result, 16'h0001);
    wr(0);
    wr(9);
    launch(c);
    check("t3_zero_not_stored", result, 9);

    // 4: fill, overflow write, drain
    for (int i = 1; i <= DEPTH; i++) wr(i[W-1:0]);
    check("t4_full", full, 1);
    wr(9);
    launch(c);
    check("t4_result", result, 36);
    check("t4_empty_after", full, 0);

    // 5: start on empty, start mid-stream
    start_l = 0; step(); start_l = 1;
    check("t5_go_idle", feed_go_l, 1);
    wr(10); wr(20); wr(30);
    start_l = 0; step(); start_l = 1;
    step();
    start_l = 0; step(); start_l = 1;
    c = 0;
    while (!result_valid && c < 40) begin step(); c++; end
    check("t5_result", result, 60);

    // 6: reset during STREAM, then a fresh run
    wr(1); wr(2); wr(3); wr(4);
    start_l = 0; step(); start_l = 1;
    step();
    do_reset();
    wr(2); wr(2);
    launch(c);
    check("t6_result", result, 4);

    // Randomized traffic with variable accumulator done latency
    for (int i = 0; i < 600; i++) begin
      if (!busy) dly = $urandom_range(0, 2);
      wr_en   = ($urandom % 2) == 0;
      wr_data = (($urandom % 8) == 0) ? '0 : W'($urandom);
      start_l = ($urandom % 10) != 0;
      step();
    end
    wr_en = 0; start_l = 1;
    c = 0;
    while (busy && c < 60) begin step(); c++; end
    check("drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
